// File: rtl/pc_unit_pkg.sv
// Shared definitions for the fetch program-counter unit: reset/exception
// vector defaults, the sequential increment and the redirect-source code
// that trace and debug logic also decode.
package pc_unit_pkg;

    localparam logic [31:0] DEF_INITIAL_PC   = 32'h0000_0000;
    localparam logic [31:0] DEF_EXCEPTION_PC = 32'h0000_0080;
    localparam int          DEF_INSTR_BYTES  = 4;

    // Which source produced the next fetch address (oldest stage first).
    typedef enum logic [2:0] {
        SRC_EXC = 3'd0,
        SRC_BR  = 3'd1,
        SRC_JMP = 3'd2,
        SRC_RET = 3'd3,
        SRC_SEQ = 3'd4
    } redirect_src_e;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack. ptr names the next free slot, so the top
// entry sits at ptr-1. A push into a full stack overwrites the oldest entry
// and the count saturates at RAS_DEPTH. push together with pop replaces the
// top entry in place.
module ras_stack #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push,
    input  logic                           pop,
    input  logic                           flush,
    input  logic [XLEN-1:0]                push_data,
    output logic [XLEN-1:0]                top,
    output logic [$clog2(RAS_DEPTH):0]     count
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(RAS_DEPTH);

    logic [XLEN-1:0]  mem [RAS_DEPTH];
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] top_idx;
    logic             empty;
    logic             do_push;
    logic             do_pop;
    logic             do_replace;

    assign top_idx    = ptr - PTR_W'(1);
    assign top        = mem[top_idx];
    assign empty      = (count == '0);
    // Replacing needs an existing top; on an empty stack it degrades to a push.
    assign do_replace = push && pop && !empty;
    assign do_push    = push && !do_replace;
    assign do_pop     = pop && !push && !empty;

    // Pointer and occupancy bookkeeping; flush discards every entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr   <= '0;
            count <= '0;
        end else if (flush) begin
            ptr   <= '0;
            count <= '0;
        end else if (do_push) begin
            ptr <= ptr + PTR_W'(1);
            if (count != FULL)
                count <= count + CNT_W'(1);
        end else if (do_pop) begin
            ptr   <= top_idx;
            count <= count - CNT_W'(1);
        end
    end

    // Entry storage; contents are meaningless until pushed, so no reset.
    always_ff @(posedge clk) begin
        if (!flush) begin
            if (do_push)
                mem[ptr] <= push_data;
            else if (do_replace)
                mem[top_idx] <= push_data;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Fetch program-counter unit: picks the next fetch address from exception,
// branch, jump, predicted return or sequential sources, holds on stall, and
// predicts call/return targets through an internal return-address stack.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] INITIAL_PC   = XLEN'(DEF_INITIAL_PC),
    parameter logic [XLEN-1:0] EXCEPTION_PC = XLEN'(DEF_EXCEPTION_PC),
    parameter int              INSTR_BYTES  = DEF_INSTR_BYTES,
    parameter int              RAS_DEPTH    = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       stall,
    input  logic                       is_exception,
    input  logic                       is_branch,
    input  logic [XLEN-1:0]            pc_branch,
    input  logic                       is_jump,
    input  logic [XLEN-1:0]            pc_jump,
    input  logic                       is_call,
    input  logic                       is_return,
    output logic [XLEN-1:0]            pc,
    output logic [$clog2(RAS_DEPTH):0] ras_count,
    output logic                       ras_underflow
);

    redirect_src_e   src;
    logic            hold;
    logic [XLEN-1:0] pc_seq;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] ras_top;
    logic            ras_push;
    logic            ras_pop;
    logic            ras_flush;
    logic            ras_empty;
    logic            underflow_next;

    // Sequential address wraps modulo 2^XLEN.
    assign pc_seq    = pc + XLEN'(INSTR_BYTES);
    assign ras_empty = (ras_count == '0);

    // Oldest redirect wins; stall only blocks the younger sources.
    always_comb begin
        src  = SRC_SEQ;
        hold = 1'b0;
        if (is_exception)
            src = SRC_EXC;
        else if (is_branch)
            src = SRC_BR;
        else if (stall)
            hold = 1'b1;
        else if (is_jump)
            src = SRC_JMP;
        else if (is_return && !ras_empty)
            src = SRC_RET;
    end

    // Next address and RAS side effects of the winning source; losers are
    // wrong-path and leave the stack alone.
    always_comb begin
        pc_next        = pc_seq;
        ras_push       = 1'b0;
        ras_pop        = 1'b0;
        ras_flush      = 1'b0;
        underflow_next = 1'b0;
        case (src)
            SRC_EXC: begin
                pc_next   = EXCEPTION_PC;
                ras_flush = 1'b1;
            end
            SRC_BR: pc_next = pc_branch;
            SRC_JMP: begin
                pc_next  = pc_jump;
                ras_push = is_call;
                // call+return: push and pop together replace the top entry
                ras_pop  = is_call && is_return;
            end
            SRC_RET: begin
                pc_next = ras_top;
                ras_pop = 1'b1;
            end
            default: begin
                if (hold)
                    pc_next = pc;
                else
                    // reaching here with a return means the stack was empty
                    underflow_next = is_return;
            end
        endcase
    end

    // Fetch PC register and registered underflow pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc            <= INITIAL_PC;
            ras_underflow <= 1'b0;
        end else begin
            pc            <= pc_next;
            ras_underflow <= underflow_next;
        end
    end

    ras_stack #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (ras_push),
        .pop       (ras_pop),
        .flush     (ras_flush),
        .push_data (pc_seq),
        .top       (ras_top),
        .count     (ras_count)
    );

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed vector table, hand-written corner
// sequences and randomized traffic against a queue-based reference model.
module tb_pc_unit;

    localparam logic [31:0] INIT_PC = 32'h0000_0000;
    localparam logic [31:0] EXC_PC  = 32'h0000_0080;
    localparam int          DEPTH   = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, is_exception, is_branch, is_jump, is_call, is_return;
    logic [31:0] pc_branch, pc_jump, pc;
    logic [2:0]  ras_count;
    logic        ras_underflow;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: fetch pc, return stack as a queue (newest at back).
    logic [31:0] m_pc;
    logic [31:0] m_ras[$];
    bit          m_uf;

    typedef struct {
        logic        s, e, b;
        logic [31:0] pb;
        logic        j;
        logic [31:0] pj;
        logic        c, r;
        logic [31:0] epc;
        int          ecnt;
        logic        euf;
    } vec_t;

    vec_t vecs[18];

    pc_unit #(
        .XLEN         (32),
        .INITIAL_PC   (INIT_PC),
        .EXCEPTION_PC (EXC_PC),
        .INSTR_BYTES  (4),
        .RAS_DEPTH    (DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .is_exception  (is_exception),
        .is_branch     (is_branch),
        .pc_branch     (pc_branch),
        .is_jump       (is_jump),
        .pc_jump       (pc_jump),
        .is_call       (is_call),
        .is_return     (is_return),
        .pc            (pc),
        .ras_count     (ras_count),
        .ras_underflow (ras_underflow)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_pc = INIT_PC;
        m_ras.delete();
        m_uf = 1'b0;
    endfunction

    // One clock of the architectural rules, written from the priority list.
    function automatic void model_update(input bit s, input bit e, input bit b,
                                         input logic [31:0] pb, input bit j,
                                         input logic [31:0] pj, input bit c, input bit r);
        bit uf = 1'b0;
        logic [31:0] ret_addr;
        ret_addr = m_pc + 32'd4;
        if (e) begin
            m_pc = EXC_PC;
            m_ras.delete();
        end else if (b) begin
            m_pc = pb;
        end else if (s) begin
            // hold everything
        end else if (j) begin
            if (c) begin
                if (r && m_ras.size() > 0)
                    m_ras[m_ras.size()-1] = ret_addr;
                else begin
                    if (m_ras.size() == DEPTH)
                        void'(m_ras.pop_front());
                    m_ras.push_back(ret_addr);
                end
            end
            m_pc = pj;
        end else if (r) begin
            if (m_ras.size() > 0)
                m_pc = m_ras.pop_back();
            else begin
                m_pc = ret_addr;
                uf   = 1'b1;
            end
        end else begin
            m_pc = ret_addr;
        end
        m_uf = uf;
    endfunction

    task automatic cycle(input bit s, input bit e, input bit b, input logic [31:0] pb,
                         input bit j, input logic [31:0] pj, input bit c, input bit r);
        stall = s; is_exception = e; is_branch = b; pc_branch = pb;
        is_jump = j; pc_jump = pj; is_call = c; is_return = r;
        model_update(s, e, b, pb, j, pj, c, r);
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_pc"}, pc, m_pc);
        check({tag, "_cnt"}, ras_count, m_ras.size());
        check({tag, "_uf"}, ras_underflow, m_uf);
    endtask

    initial begin
        logic [31:0] ret_exp [4];
        ret_exp[0] = 32'h54; ret_exp[1] = 32'h44; ret_exp[2] = 32'h34; ret_exp[3] = 32'h24;

        //          s     e     b     pb            j     pj            c     r     epc           cnt uf
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 1'b0, 32'h4,        0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 1'b0, 32'h4,        0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 32'h200,     1'b0, 32'h0,       1'b0, 1'b0, 32'h200,      0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,       1'b1, 32'h800,     1'b1, 1'b0, 32'h800,      1, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 1'b1, 32'h204,      0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 1'b1, 32'h208,      0, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 1'b0, 32'h20C,      0, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 32'h40,      1'b1, 32'h999,     1'b0, 1'b0, 32'h80,       0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 32'h40,      1'b0, 32'h0,       1'b0, 1'b0, 32'h40,       0, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,       1'b1, 32'h100,     1'b0, 1'b0, 32'h100,      0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h0,       1'b1, 32'h300,     1'b1, 1'b0, 32'h300,      1, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 32'h0,       1'b1, 32'h500,     1'b1, 1'b1, 32'h500,      1, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 1'b1, 32'h304,      0, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 1'b1, 32'h304,      0, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 32'h0,       1'b1, 32'h777,     1'b1, 1'b0, 32'h304,      0, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 1'b1, 32'h308,      0, 1'b1};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 1'b1, 32'h30C,      0, 1'b1};
        vecs[17] = '{1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 1'b0, 32'h310,      0, 1'b0};

        // Reset state
        reset = 1'b1;
        stall = 1'b0; is_exception = 1'b0; is_branch = 1'b0; is_jump = 1'b0;
        is_call = 1'b0; is_return = 1'b0; pc_branch = '0; pc_jump = '0;
        model_reset();
        #12;
        check("reset_pc", pc, INIT_PC);
        check("reset_cnt", ras_count, 0);
        check("reset_uf", ras_underflow, 0);
        @(negedge clk);
        reset = 1'b0;

        // Directed vector table
        foreach (vecs[i]) begin
            cycle(vecs[i].s, vecs[i].e, vecs[i].b, vecs[i].pb,
                  vecs[i].j, vecs[i].pj, vecs[i].c, vecs[i].r);
            check($sformatf("vec%0d_pc", i), pc, vecs[i].epc);
            check($sformatf("vec%0d_cnt", i), ras_count, vecs[i].ecnt);
            check($sformatf("vec%0d_uf", i), ras_underflow, vecs[i].euf);
        end

        // Sequential wrap and stall hold
        cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 1'b0);
        check("wrap_setup_pc", pc, 32'hFFFF_FFFC);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        check("wrap_pc", pc, 32'h0);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
            check($sformatf("stall_hold%0d_pc", k), pc, 32'h0);
        end

        // RAS overflow then underflow
        cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            cycle(1'b0, 1'b0, 1'b1, 32'(k * 16), 1'b0, 32'h0, 1'b0, 1'b0);
            cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h1000, 1'b1, 1'b0);
        end
        check("ovf_cnt", ras_count, 4);
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
            check($sformatf("ret%0d_pc", k), pc, ret_exp[k]);
            check($sformatf("ret%0d_uf", k), ras_underflow, 0);
        end
        check("drained_cnt", ras_count, 0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        check("udf_pc", pc, 32'h28);
        check("udf_pulse", ras_underflow, 1);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        check("udf_clear", ras_underflow, 0);
        check("udf_next_pc", pc, 32'h2C);

        // Wrong-path suppression and call+return replacement
        cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 32'h10, 1'b0, 32'h0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h700, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h710, 1'b1, 1'b0);
        check("sup_setup_cnt", ras_count, 2);
        cycle(1'b0, 1'b0, 1'b1, 32'h600, 1'b0, 32'h0, 1'b0, 1'b1);
        check("sup_br_pc", pc, 32'h600);
        check("sup_br_cnt", ras_count, 2);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h900, 1'b1, 1'b1);
        check("callret_pc", pc, 32'h900);
        check("callret_cnt", ras_count, 2);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        check("callret_top_pc", pc, 32'h604);
        check("callret_top_cnt", ras_count, 1);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        check("callret_below_pc", pc, 32'h14);

        // Asynchronous reset mid-cycle
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h100, 1'b1, 1'b0);
        check("arst_setup_pc", pc, 32'h100);
        check("arst_setup_cnt", ras_count, 1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_pc", pc, INIT_PC);
        check("arst_cnt", ras_count, 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;

        // Randomized traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            bit          s, e, b, j, c, r;
            logic [31:0] pb, pj;
            s  = ($urandom_range(0, 3) == 0);
            e  = ($urandom_range(0, 31) == 0);
            b  = ($urandom_range(0, 7) == 0);
            j  = ($urandom_range(0, 3) == 0);
            c  = ($urandom_range(0, 1) == 1);
            r  = ($urandom_range(0, 2) == 0);
            pb = $urandom;
            pj = $urandom;
            cycle(s, e, b, pb, j, pj, c, r);
            check_model($sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised next-generation program-counter unit for the fetch stage.
- Holds the fetch PC and selects the next PC from these sources:
  - exception vector
  - resolved branch
  - decoded jump
  - predicted return from an internal return-address stack (RAS)
  - sequential increment
- Adds fetch-stall hold, age-based redirect priority and call/return prediction.
- Sits between the decode/execute redirect logic and the instruction-memory address port.

Parameters:
- XLEN, 32, address width in bits.
- INITIAL_PC, 32'h0000_0000, PC value loaded on reset (XLEN bits).
- EXCEPTION_PC, 32'h0000_0080, exception handler vector (XLEN bits).
- INSTR_BYTES, 4, sequential increment.
- RAS_DEPTH, 4, number of RAS entries; power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  fetch cannot accept a new address this cycle.
- is_exception  in  1  exception redirect (oldest stage).
- is_branch  in  1  resolved taken-branch redirect.
- pc_branch  in  XLEN  branch target.
- is_jump  in  1  decoded jump redirect.
- pc_jump  in  XLEN  jump target.
- is_call  in  1  qualifies is_jump as jump-and-link; push return address.
- is_return  in  1  fetched instruction is a return; predict the target from the RAS.
- pc  out  XLEN  current fetch address, registered.
- ras_count  out  clog2(RAS_DEPTH)+1  number of valid RAS entries.
- ras_underflow  out  1  one-cycle pulse: return seen with an empty RAS.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - pc = INITIAL_PC
  - RAS write pointer = 0, ras_count = 0, ras_underflow = 0
  - RAS entry contents are don't-care.
- Priority, evaluated combinationally each cycle; the oldest source wins:
  1. is_exception: next = EXCEPTION_PC; RAS flushed (count = 0, ptr = 0).
  2. is_branch: next = pc_branch; RAS unchanged.
  3. is_jump: next = pc_jump; if is_call, push pc + INSTR_BYTES.
  4. is_return with ras_count > 0: next = top entry; pop.
  5. is_return with ras_count = 0: next = pc + INSTR_BYTES; ras_underflow = 1 next cycle.
  6. Otherwise: next = pc + INSTR_BYTES.
- Stall interaction:
  - stall with no exception or branch: pc holds, RAS holds, and jump, call and return are ignored (the instruction will be refetched).
  - Exception and branch override stall: they update pc and apply their RAS effect even while stalled.
- Wrong-path suppression: when exception or branch wins, is_call and is_return in the same cycle have no RAS effect.
- Call and return in the same cycle: the jump wins (next = pc_jump); the top entry is replaced with pc + INSTR_BYTES; count unchanged.
- RAS push when full (count = RAS_DEPTH):
  - Circular overwrite of the oldest entry.
  - ptr advances modulo RAS_DEPTH; count stays saturated at RAS_DEPTH.
- RAS pop: ptr decrements modulo RAS_DEPTH; count decrements.
- Arithmetic: pc + INSTR_BYTES is an XLEN-bit sum; it wraps modulo 2^XLEN with no carry out. Targets are used unaligned-unchecked.
- Latency: one cycle from redirect input to the pc output.
- ras_underflow: registered; high exactly one cycle per underflow event; 0 whenever stall blocks the return.

Decomposition:
- Shared package/define file holds:
  - INITIAL_PC and EXCEPTION_PC defaults
  - INSTR_BYTES
  - a redirect-source encoding: SRC_EXC, SRC_BR, SRC_JMP, SRC_RET, SRC_SEQ (3 bits), also used by trace and debug logic.
- Sub-module ras_stack (parameters XLEN, RAS_DEPTH):
  - inputs: push, pop, flush, push_data
  - outputs: top, count
  - owns the circular pointer and saturation.
- pc_unit owns priority selection, the pc register and underflow generation.

Test Plan:
- Reset during run: pc = 32'h100, reset asserted asynchronously mid-cycle -> pc = INITIAL_PC immediately; ras_count = 0; no clock edge required.
- Sequential and wrap: pc = 32'hFFFF_FFFC, no inputs -> next pc = 32'h0; stall = 1 for 3 cycles -> pc holds 32'h0.
- Priority: is_exception, is_branch (pc_branch = 32'h40) and is_jump all = 1 with stall = 1 -> pc = EXCEPTION_PC, ras_count = 0; next, branch alone under stall -> pc = 32'h40.
- Call/return: pc = 32'h200, jump and call to 32'h800 -> pc = 32'h800, count = 1; then is_return -> pc = 32'h204, count = 0.
- Overflow/underflow (RAS_DEPTH = 4):
  - 5 calls from PCs 0x10, 0x20, 0x30, 0x40, 0x50 -> count = 4.
  - 4 returns -> pcs 0x54, 0x44, 0x34, 0x24.
  - 5th return -> sequential pc, ras_underflow pulses for 1 cycle.
- Suppression: branch together with is_return and count = 2 -> pc = pc_branch, count stays 2; call and return together -> pc = pc_jump, count unchanged, top = old pc + 4.
